// File: rtl/mem_request_ctrl.sv
// Data-memory request stage: alignment check, bus request/ack handshake,
// store lane steering and hand-off of the raw read word downstream.
module mem_request_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   input  logic [1:0]  memOp,
   input  logic [1:0]  memSize,
   input  logic [31:0] aluIn,
   input  logic [31:0] storeData,
   output logic        stall,
   output logic        memReq,
   output logic        memWe,
   output logic [31:0] memAddr,
   output logic [31:0] memWdata,
   output logic [3:0]  memWstrb,
   input  logic        memAck,
   input  logic [31:0] memRdata,
   output logic [31:0] memOut,
   output logic [31:0] addrOut,
   output logic [1:0]  memSizeOut,
   output logic [1:0]  memOpOut,
   output logic        requestDone,
   output logic        misalignFault,
   output logic        busFault
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE,
      FAULT
   } state_t;

   localparam int unsigned TO_M1 = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             misalign_q;
   logic             we_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       wstrb_q;
   logic [31:0]      out_q;
   logic [31:0]      addr_out_q;
   logic [1:0]       size_q;
   logic [1:0]       op_q;

   logic             active_d;
   logic             bad_d;
   logic             accept_d;
   logic             timeout_d;
   logic [31:0]      wdata_d;
   logic [3:0]       wstrb_d;

   // Alignment check, store lane steering and acceptance decode
   always_comb begin
      bad_d   = 1'b0;
      wdata_d = 32'h0;
      wstrb_d = 4'b0000;
      unique case (memSize)
         2'b00: bad_d = 1'b0;
         2'b01: bad_d = aluIn[0];
         2'b10: bad_d = |aluIn[1:0];
         2'b11: bad_d = 1'b1;
      endcase
      if (memOp == 2'b11) begin
         unique case (memSize)
            2'b00: begin
               wdata_d = {24'h0, storeData[7:0]} << {aluIn[1:0], 3'b000};
               wstrb_d = 4'b0001 << aluIn[1:0];
            end
            2'b01: begin
               wdata_d = {16'h0, storeData[15:0]} << {aluIn[1:0], 3'b000};
               wstrb_d = 4'b0011 << aluIn[1:0];
            end
            2'b10: begin
               wdata_d = storeData;
               wstrb_d = 4'b1111;
            end
            2'b11: begin
               wdata_d = 32'h0;
               wstrb_d = 4'b0000;
            end
         endcase
      end
      active_d  = (state_q == IDLE) && reqValid && (memOp != 2'b00);
      accept_d  = active_d && !bad_d;
      timeout_d = (TIMEOUT != 0) && (cnt_q == TO_LAST);
   end

   // Pipeline hold: accepting cycle plus every cycle spent waiting on the bus
   always_comb begin
      stall = accept_d || (state_q == REQ);
   end

   // Request FSM with latched bus and hand-off registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'b0000;
         out_q      <= 32'h0;
         addr_out_q <= 32'h0;
         size_q     <= 2'b00;
         op_q       <= 2'b00;
      end else begin
         misalign_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (active_d && bad_d) begin
                  misalign_q <= 1'b1;
               end else if (accept_d) begin
                  state_q    <= REQ;
                  cnt_q      <= '0;
                  we_q       <= (memOp == 2'b11);
                  addr_q     <= {aluIn[31:2], 2'b00};
                  wdata_q    <= wdata_d;
                  wstrb_q    <= wstrb_d;
                  addr_out_q <= aluIn;
                  size_q     <= memSize;
                  op_q       <= memOp;
               end
            end
            REQ: begin
               if (memAck) begin
                  if (!we_q) begin
                     out_q <= memRdata;
                  end
                  state_q <= DONE;
               end else if (timeout_d) begin
                  state_q <= FAULT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            FAULT: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state
   always_comb begin
      memReq        = (state_q == REQ);
      requestDone   = (state_q == DONE);
      busFault      = (state_q == FAULT);
      misalignFault = misalign_q;
      memWe         = we_q;
      memAddr       = addr_q;
      memWdata      = wdata_q;
      memWstrb      = wstrb_q;
      memOut        = out_q;
      addrOut       = addr_out_q;
      memSizeOut    = size_q;
      memOpOut      = op_q;
   end

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed table-driven bench for mem_request_ctrl with TIMEOUT=4.
module tb_mem_request_ctrl;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic [1:0]  memOp;
   logic [1:0]  memSize;
   logic [31:0] aluIn;
   logic [31:0] storeData;
   logic        stall;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWdata;
   logic [3:0]  memWstrb;
   logic        memAck;
   logic [31:0] memRdata;
   logic [31:0] memOut;
   logic [31:0] addrOut;
   logic [1:0]  memSizeOut;
   logic [1:0]  memOpOut;
   logic        requestDone;
   logic        misalignFault;
   logic        busFault;

   mem_request_ctrl #(
      .TIMEOUT(4),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .reqValid(reqValid),
      .memOp(memOp),
      .memSize(memSize),
      .aluIn(aluIn),
      .storeData(storeData),
      .stall(stall),
      .memReq(memReq),
      .memWe(memWe),
      .memAddr(memAddr),
      .memWdata(memWdata),
      .memWstrb(memWstrb),
      .memAck(memAck),
      .memRdata(memRdata),
      .memOut(memOut),
      .addrOut(addrOut),
      .memSizeOut(memSizeOut),
      .memOpOut(memOpOut),
      .requestDone(requestDone),
      .misalignFault(misalignFault),
      .busFault(busFault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 accepted, 1 misaligned, 2 ignored
   typedef struct {
      logic [1:0]  op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] sd;
      int          ack_at;
      logic [31:0] rdata;
      int          kind;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_strb;
      logic        e_we;
      int          e_req;
      logic        e_bus;
      logic [31:0] e_out;
   } vec_t;

   vec_t vecs[13];
   int pass_cnt;
   int total_cnt;
   logic [31:0] last_addr;
   logic [1:0]  last_size;
   logic [1:0]  last_op;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         pass_cnt++;
   endtask

   task automatic run_txn(input vec_t v);
      int reqc;
      int stc;
      bit unstable;
      reqc = 0;
      stc = 1;
      unstable = 1'b0;
      reqValid = 1'b1;
      memOp = v.op;
      memSize = v.size;
      aluIn = v.addr;
      storeData = v.sd;
      memAck = 1'b0;
      #1;
      chk("stall_accept", {31'h0, stall}, {31'h0, v.kind == 0});
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      memOp = 2'b00;
      if (v.kind == 1) begin
         chk("misalign_pulse", {31'h0, misalignFault}, 32'h1);
         chk("misalign_noreq", {31'h0, memReq}, 32'h0);
         @(posedge clk);
         #1;
         chk("misalign_end", {31'h0, misalignFault}, 32'h0);
         chk("misalign_nodone", {31'h0, requestDone}, 32'h0);
         chk("misalign_addrout", addrOut, last_addr);
      end else if (v.kind == 2) begin
         chk("ignore_noreq", {31'h0, memReq}, 32'h0);
         chk("ignore_nofault", {31'h0, misalignFault}, 32'h0);
         chk("ignore_addrout", addrOut, last_addr);
      end else begin
         chk("addr", memAddr, v.e_addr);
         chk("wdata", memWdata, v.e_wdata);
         chk("wstrb", {28'h0, memWstrb}, {28'h0, v.e_strb});
         chk("we", {31'h0, memWe}, {31'h0, v.e_we});
         for (int k = 0; k < 30; k++) begin
            if (!memReq) break;
            reqc++;
            if (stall) stc++;
            if (memAddr !== v.e_addr || memWdata !== v.e_wdata ||
                memWstrb !== v.e_strb || memWe !== v.e_we)
               unstable = 1'b1;
            memAck = (reqc - 1 == v.ack_at);
            memRdata = memAck ? v.rdata : 32'h0BAD0BAD;
            @(posedge clk);
            #1;
            memAck = 1'b0;
            memRdata = 32'h0;
         end
         chk("req_cycles", reqc, v.e_req);
         chk("stall_cycles", stc, v.e_req + 1);
         chk("bus_stable", {31'h0, unstable}, 32'h0);
         chk("done", {31'h0, requestDone}, {31'h0, !v.e_bus});
         chk("busfault", {31'h0, busFault}, {31'h0, v.e_bus});
         chk("stall_tail", {31'h0, stall}, 32'h0);
         chk("memout", memOut, v.e_out);
         chk("addrout", addrOut, v.addr);
         chk("sizeout", {30'h0, memSizeOut}, {30'h0, v.size});
         chk("opout", {30'h0, memOpOut}, {30'h0, v.op});
         last_addr = v.addr;
         last_size = v.size;
         last_op = v.op;
         @(posedge clk);
         #1;
         chk("done_pulse", {31'h0, requestDone}, 32'h0);
         chk("bus_pulse", {31'h0, busFault}, 32'h0);
      end
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      last_addr = 32'h0;
      last_size = 2'b00;
      last_op = 2'b00;
      rst = 1'b1;
      reqValid = 1'b0;
      memOp = 2'b00;
      memSize = 2'b00;
      aluIn = 32'h0;
      storeData = 32'h0;
      memAck = 1'b0;
      memRdata = 32'h0;

      vecs[0]  = '{2'b01, 2'b10, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0,
                   32'h100, 32'h0, 4'b0000, 1'b0, 1, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{2'b11, 2'b00, 32'h203, 32'hA5, 0, 32'h0, 0,
                   32'h200, 32'hA5000000, 4'b1000, 1'b1, 1, 1'b0,
                   32'hDEADBEEF};
      vecs[2]  = '{2'b11, 2'b01, 32'h302, 32'h1234, 1, 32'h0, 0,
                   32'h300, 32'h12340000, 4'b1100, 1'b1, 2, 1'b0,
                   32'hDEADBEEF};
      vecs[3]  = '{2'b01, 2'b10, 32'h102, 32'h0, 0, 32'h0, 1,
                   32'h0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 32'h0};
      vecs[4]  = '{2'b10, 2'b01, 32'h101, 32'h0, 0, 32'h0, 1,
                   32'h0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 32'h0};
      vecs[5]  = '{2'b01, 2'b11, 32'h0, 32'h0, 0, 32'h0, 1,
                   32'h0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 32'h0};
      vecs[6]  = '{2'b00, 2'b10, 32'h500, 32'h0, 0, 32'h0, 2,
                   32'h0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 32'h0};
      vecs[7]  = '{2'b10, 2'b10, 32'h40, 32'h0, 99, 32'h0, 0,
                   32'h40, 32'h0, 4'b0000, 1'b0, 4, 1'b1, 32'hDEADBEEF};
      vecs[8]  = '{2'b01, 2'b10, 32'h44, 32'h0, 3, 32'h89ABCDEF, 0,
                   32'h44, 32'h0, 4'b0000, 1'b0, 4, 1'b0, 32'h89ABCDEF};
      vecs[9]  = '{2'b11, 2'b10, 32'h80, 32'hCAFEF00D, 0, 32'h0, 0,
                   32'h80, 32'hCAFEF00D, 4'b1111, 1'b1, 1, 1'b0,
                   32'h89ABCDEF};
      vecs[10] = '{2'b11, 2'b00, 32'h11, 32'h12345677, 2, 32'h0, 0,
                   32'h10, 32'h00007700, 4'b0010, 1'b1, 3, 1'b0,
                   32'h89ABCDEF};
      vecs[11] = '{2'b11, 2'b01, 32'h20, 32'hFFFFBEEF, 0, 32'h0, 0,
                   32'h20, 32'h0000BEEF, 4'b0011, 1'b1, 1, 1'b0,
                   32'h89ABCDEF};
      vecs[12] = '{2'b10, 2'b00, 32'h7, 32'h0, 0, 32'h01020304, 0,
                   32'h4, 32'h0, 4'b0000, 1'b0, 1, 1'b0, 32'h01020304};

      #12;
      chk("rst_memreq", {31'h0, memReq}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      chk("rst_done", {31'h0, requestDone}, 32'h0);
      chk("rst_memout", memOut, 32'h0);
      chk("rst_addrout", addrOut, 32'h0);
      chk("rst_wstrb", {28'h0, memWstrb}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 13; i++) run_txn(vecs[i]);

      // Reset asserted while the bus request is outstanding
      reqValid = 1'b1;
      memOp = 2'b01;
      memSize = 2'b10;
      aluIn = 32'h600;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      memOp = 2'b00;
      chk("midreq_active", {31'h0, memReq}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("midreq_memreq", {31'h0, memReq}, 32'h0);
      chk("midreq_stall", {31'h0, stall}, 32'h0);
      chk("midreq_addr", memAddr, 32'h0);
      chk("midreq_addrout", addrOut, 32'h0);
      chk("midreq_memout", memOut, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_addr = 32'h0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", {31'h0, memReq}, 32'h0);
      run_txn(vecs[0]);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
